serial_port_bus_if: RTL and testbench
=====================================

Name: serial_port_bus_if

Overview:
Bus-side front end for the serial port transmitter/receiver. Buffers CPU writes in a TX FIFO and feeds them to the serial port over its toggle handshake (din/wrin/wrout). Captures received bytes from the serial port's toggle strobe (dout/rdout) into an RX FIFO. Exposes a 2-register CPU interface with status and an interrupt line. Same clock domain as the serial port.

Parameters:
DEPTH, 16, entries per FIFO; power of two, minimum 2
PTR_W, 4, log2(DEPTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cs  in  1  bus select strobe, one cycle per access
we  in  1  1 = write, 0 = read (qualified by cs)
addr  in  1  0 = DATA, 1 = STATUS/CTRL
wdata  in  8  bus write data
rdata  out  8  bus read data, registered
irq  out  1  level interrupt
sp_din  out  8  byte to serial port transmitter
sp_wrin  out  1  TX request toggle to serial port
sp_wrout  in  1  TX acknowledge toggle from serial port
sp_dout  in  8  received byte from serial port
sp_rdout  in  1  RX toggle from serial port; a change means a new byte

Behaviour:
- Reset (async assert, sync release): rdata=0, irq=0, sp_din=0, sp_wrin=0. FIFOs empty, overrun=0, irq enables=0, prime=1, rx_last=0.
- Prime cycle: the serial port has no reset, so its toggle levels are unknown. On the first clk edge with rst_n high and prime=1: sp_wrin<=sp_wrout, rx_last<=sp_rdout, prime<=0. No transfer occurs in this cycle.
- TX path, pending = sp_wrin ^ sp_wrout:
  - When pending=0, prime=0 and TX FIFO is non-empty: sp_din<=head, sp_wrin<=~sp_wrin, pop head, all in one cycle.
  - While pending=1, sp_din is held stable. The serial port samples it only at its baud tick.
  - At most one byte is outstanding.
- RX path:
  - When sp_rdout != rx_last and prime=0: rx_last<=sp_rdout and sp_dout is pushed into the RX FIFO. sp_dout is already stable when the toggle is seen.
  - If the RX FIFO is full and not popped this cycle: byte is dropped and overrun<=1 (sticky).
  - If full and popped in the same cycle: byte is accepted and count is unchanged.
- DATA write (cs&we&addr=0): push wdata to TX FIFO. If full, it is silently dropped.
- DATA read (cs&~we&addr=0):
  - rdata<=RX head on the next edge (1-cycle latency), and the head is popped.
  - If empty: rdata<=0, no pop.
- STATUS read (addr=1): rdata<={4'b0, tx_idle, overrun, tx_not_full, rx_not_empty}, 1-cycle latency. overrun clears on this read; a set in the same cycle wins.
- tx_idle = TX FIFO empty & ~pending.
- CTRL write (addr=1): rx_ie<=wdata[0], tx_ie<=wdata[1].
- irq (registered) = (rx_ie & rx_not_empty) | (tx_ie & tx_idle) | (rx_ie & overrun).
- When cs is idle, rdata holds its last value.
- FIFO pointers are PTR_W+1 bits and wrap modulo 2*DEPTH. full = MSBs differ and the rest equal; empty = all bits equal.
- TX FIFO push and pop in the same cycle are both honoured. A push when full is dropped even if a pop occurs that cycle.
- Reset mid-transfer: FIFOs are flushed and a fresh prime cycle resynchronises. A byte already latched by the serial port still completes on the line.

Decomposition:
- Shared package:
  - register address constants ADDR_DATA=0, ADDR_STAT=1
  - status bit indices RX_NE=0, TX_NF=1, OVR=2, TX_IDLE=3
  - ctrl bit indices RX_IE=0, TX_IE=1
- One sub-module, sync_fifo: parameterised DEPTH/width, push/pop/full/empty/head, async active-low reset. Instantiated twice (TX, RX).
- Toggle logic and register decode stay in the top level.

Test Plan:
- Reset with sp_wrout=1, sp_rdout=1, then release -> after the prime cycle, sp_wrin=1 and no RX push. STATUS reads 0x0A (tx_idle, tx_not_full).
- Write 0x55, 0xAA to DATA; model ack by toggling sp_wrout 400 cycles after each sp_wrin change -> sp_din=0x55, then 0xAA after the first ack. sp_din is stable while pending. STATUS bit3 is set only after the second ack.
- Toggle sp_rdout with sp_dout=0x3C, then 0xC3 -> DATA reads return 0x3C, then 0xC3, each 1 cycle after cs. A third read returns 0x00 and rx_not_empty=0.
- Deliver 17 RX bytes (0x00..0x10) with no reads -> STATUS=0x05 (overrun|rx_ne, TX bits as applicable). 16 reads yield 0x00..0x0F. A second STATUS read shows overrun=0.
- Write 17 TX bytes while the serial port holds ack -> 17th is dropped. tx_not_full is 0 after 16 with one byte outstanding, and 0x10 is never seen on sp_din.
- Write CTRL=0x01, then deliver one RX byte -> irq rises within 2 cycles of the sp_rdout toggle and falls 1 cycle after the DATA read that empties the FIFO.

Source files
------------

// File: rtl/serial_port_bus_if_pkg.sv
// Shared constants for the serial port bus front end: register map and bit positions.
package serial_port_bus_if_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_STAT = 1'b1;

  localparam int RX_NE   = 0;
  localparam int TX_NF   = 1;
  localparam int OVR     = 2;
  localparam int TX_IDLE = 3;

  localparam int RX_IE = 0;
  localparam int TX_IE = 1;

  function automatic logic [7:0] pack_status(input logic tx_idle, input logic ovr,
                                             input logic tx_nf, input logic rx_ne);
    logic [7:0] s;
    s          = 8'h00;
    s[TX_IDLE] = tx_idle;
    s[OVR]     = ovr;
    s[TX_NF]   = tx_nf;
    s[RX_NE]   = rx_ne;
    return s;
  endfunction

endpackage

// File: rtl/serial_port_bus_if_fifo.sv
// Synchronous FIFO with wrap-bit pointers; optional acceptance of a push into a full FIFO that pops the same cycle.
module sync_fifo #(
  parameter int DEPTH            = 16,
  parameter int PTR_W            = 4,
  parameter int W                = 8,
  parameter bit PUSH_ON_FULL_POP = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]   mem_q [DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           do_push;
  logic           do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    do_pop   = pop & ~empty;
    // A full FIFO being popped frees the slot the write lands in, if enabled.
    do_push  = push & (~full | (PUSH_ON_FULL_POP & do_pop));
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/serial_port_bus_if.sv
// CPU-side front end for the serial port: TX/RX FIFOs, toggle handshakes and a two-register bus interface.
module serial_port_bus_if
  import serial_port_bus_if_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       we,
  input  logic       addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq,
  output logic [7:0] sp_din,
  output logic       sp_wrin,
  input  logic       sp_wrout,
  input  logic [7:0] sp_dout,
  input  logic       sp_rdout
);

  logic       prime_q, prime_d;
  logic       rx_last_q, rx_last_d;
  logic       sp_wrin_q, sp_wrin_d;
  logic [7:0] sp_din_q, sp_din_d;
  logic [7:0] rdata_q, rdata_d;
  logic       irq_q, irq_d;
  logic       overrun_q, overrun_d;
  logic       rx_ie_q, rx_ie_d;
  logic       tx_ie_q, tx_ie_d;

  logic       pending, tx_idle, tx_launch, rx_toggle;
  logic       tx_push, ctrl_wr, data_rd, stat_rd, rx_pop;
  logic [7:0] tx_head, rx_head;
  logic       tx_full, tx_empty, rx_full, rx_empty;

  sync_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(8), .PUSH_ON_FULL_POP(1'b0)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_launch), .din(wdata),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(8), .PUSH_ON_FULL_POP(1'b1)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_toggle), .pop(rx_pop), .din(sp_dout),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    // A byte is outstanding while our request toggle differs from the port's acknowledge.
    pending   = sp_wrin_q ^ sp_wrout;
    tx_idle   = tx_empty & ~pending;
    tx_launch = ~prime_q & ~pending & ~tx_empty;
    rx_toggle = ~prime_q & (sp_rdout != rx_last_q);
    tx_push   = cs & we & (addr == ADDR_DATA);
    ctrl_wr   = cs & we & (addr == ADDR_STAT);
    data_rd   = cs & ~we & (addr == ADDR_DATA);
    stat_rd   = cs & ~we & (addr == ADDR_STAT);
    rx_pop    = data_rd & ~rx_empty;

    prime_d   = prime_q;
    rx_last_d = rx_last_q;
    sp_wrin_d = sp_wrin_q;
    sp_din_d  = sp_din_q;
    rdata_d   = rdata_q;
    overrun_d = overrun_q;
    rx_ie_d   = rx_ie_q;
    tx_ie_d   = tx_ie_q;

    // The serial port has no reset: adopt its toggle levels once before any transfer.
    if (prime_q) begin
      sp_wrin_d = sp_wrout;
      rx_last_d = sp_rdout;
      prime_d   = 1'b0;
    end
    if (tx_launch) begin
      sp_din_d  = tx_head;
      sp_wrin_d = ~sp_wrin_q;
    end
    if (rx_toggle) rx_last_d = sp_rdout;

    if (stat_rd) overrun_d = 1'b0;
    if (rx_toggle & rx_full & ~rx_pop) overrun_d = 1'b1;

    if (data_rd) rdata_d = rx_empty ? 8'h00 : rx_head;
    if (stat_rd) rdata_d = pack_status(tx_idle, overrun_q, ~tx_full, ~rx_empty);

    if (ctrl_wr) begin
      rx_ie_d = wdata[RX_IE];
      tx_ie_d = wdata[TX_IE];
    end

    irq_d = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_idle) | (rx_ie_q & overrun_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_q   <= 1'b1;
      rx_last_q <= 1'b0;
      sp_wrin_q <= 1'b0;
      sp_din_q  <= 8'h00;
      rdata_q   <= 8'h00;
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
      rx_ie_q   <= 1'b0;
      tx_ie_q   <= 1'b0;
    end else begin
      prime_q   <= prime_d;
      rx_last_q <= rx_last_d;
      sp_wrin_q <= sp_wrin_d;
      sp_din_q  <= sp_din_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      overrun_q <= overrun_d;
      rx_ie_q   <= rx_ie_d;
      tx_ie_q   <= tx_ie_d;
    end
  end

  assign rdata   = rdata_q;
  assign irq     = irq_q;
  assign sp_din  = sp_din_q;
  assign sp_wrin = sp_wrin_q;

endmodule

// File: tb/tb_serial_port_bus_if.sv
// Bench for serial_port_bus_if: queue-based reference model, read scoreboard and a serial-port ack responder.
module tb_serial_port_bus_if;
  import serial_port_bus_if_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b0, we = 1'b0, addr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata, sp_din;
  logic       irq, sp_wrin;
  logic       sp_wrout = 1'b1;
  logic [7:0] sp_dout = 8'h00;
  logic       sp_rdout = 1'b1;

  serial_port_bus_if #(.DEPTH(DEPTH), .PTR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq), .sp_din(sp_din), .sp_wrin(sp_wrin),
    .sp_wrout(sp_wrout), .sp_dout(sp_dout), .sp_rdout(sp_rdout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: FIFO contents as queues, one outstanding TX byte tracked by toggle levels.
  logic [7:0] m_txq[$];
  logic [7:0] m_rxq[$];
  logic [7:0] exp_q[$];
  logic       m_prime, m_rx_last, m_wrin, m_ovr, m_rxie, m_txie, m_irq;
  logic [7:0] m_din;
  logic       m_pend, m_idle, m_irq_n, m_tx_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_txq.delete();
      m_rxq.delete();
      m_prime = 1'b1; m_rx_last = 1'b0; m_wrin = 1'b0; m_din = 8'h00;
      m_ovr = 1'b0; m_rxie = 1'b0; m_txie = 1'b0; m_irq = 1'b0;
    end else begin
      m_pend    = m_wrin ^ sp_wrout;
      m_idle    = (m_txq.size() == 0) && !m_pend;
      m_irq_n   = (m_rxie && m_rxq.size() != 0) || (m_txie && m_idle) || (m_rxie && m_ovr);
      m_tx_full = (m_txq.size() >= DEPTH);
      if (cs && !we) begin
        if (addr == ADDR_DATA) begin
          if (m_rxq.size() != 0) exp_q.push_back(m_rxq.pop_front());
          else exp_q.push_back(8'h00);
        end else begin
          exp_q.push_back({4'b0000, m_idle, m_ovr, !m_tx_full, m_rxq.size() != 0});
          m_ovr = 1'b0;
        end
      end
      if (m_prime) begin
        m_wrin = sp_wrout;
        m_rx_last = sp_rdout;
        m_prime = 1'b0;
      end else begin
        if (!m_pend && m_txq.size() != 0) begin
          m_din = m_txq.pop_front();
          m_wrin = ~m_wrin;
        end
        if (sp_rdout !== m_rx_last) begin
          m_rx_last = sp_rdout;
          if (m_rxq.size() < DEPTH) m_rxq.push_back(sp_dout);
          else m_ovr = 1'b1;
        end
      end
      if (cs && we && addr == ADDR_DATA && !m_tx_full) m_txq.push_back(wdata);
      if (cs && we && addr == ADDR_STAT) begin
        m_rxie = wdata[RX_IE];
        m_txie = wdata[TX_IE];
      end
      m_irq = m_irq_n;
    end
  end

  // Monitor: read results from the scoreboard, line-side outputs against the model every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() != 0) check8("rdata", rdata, exp_q.pop_front());
      check1("sp_wrin", sp_wrin, m_wrin);
      check8("sp_din", sp_din, m_din);
      check1("irq", irq, m_irq);
    end
  end

  // Serial port transmitter stand-in: acknowledges each request after a delay.
  bit ack_en = 1'b0;
  bit ack_rand = 1'b0;
  int ack_dly = 400;
  always begin
    @(negedge clk);
    if (ack_en && rst_n && (sp_wrin !== sp_wrout)) begin
      repeat (ack_rand ? int'($urandom_range(1, 30)) : ack_dly) @(negedge clk);
      sp_wrout = ~sp_wrout;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic a);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic deliver_rx(input logic [7:0] b);
    sp_dout = b;
    @(negedge clk);
    sp_rdout = ~sp_rdout;
    @(negedge clk);
  endtask

  task automatic read_and_rx(input logic [7:0] b);
    sp_dout = b;
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = ADDR_DATA;
    sp_rdout = ~sp_rdout;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic wait_tx_drain(input int max_cycles);
    int n = 0;
    while ((m_txq.size() != 0 || m_wrin !== sp_wrout) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= max_cycles) begin
      miscompares++;
      $display("FAIL tx_drain_timeout: got %0d queued expected 0 after %0d cycles", m_txq.size(), n);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check1("wrin_after_prime", sp_wrin, 1'b1);
    idle(1);
    bus_read(ADDR_STAT);
    check8("stat_after_reset", rdata, 8'h0A);

    // Two TX bytes with slow acknowledges.
    ack_dly = 400; ack_en = 1'b1;
    bus_write(ADDR_DATA, 8'h55);
    bus_write(ADDR_DATA, 8'hAA);
    idle(3);
    check8("din_first", sp_din, 8'h55);
    idle(200);
    bus_read(ADDR_STAT);
    check1("tx_idle_early", rdata[TX_IDLE], 1'b0);
    idle(400);
    check8("din_second", sp_din, 8'hAA);
    wait_tx_drain(2000);
    ack_en = 1'b0;
    idle(2);
    bus_read(ADDR_STAT);
    check1("tx_idle_done", rdata[TX_IDLE], 1'b1);

    // Two RX bytes then an empty read.
    deliver_rx(8'h3C);
    deliver_rx(8'hC3);
    bus_read(ADDR_DATA); check8("rx_first", rdata, 8'h3C);
    bus_read(ADDR_DATA); check8("rx_second", rdata, 8'hC3);
    bus_read(ADDR_DATA); check8("rx_empty_read", rdata, 8'h00);
    bus_read(ADDR_STAT); check1("rx_ne_clear", rdata[RX_NE], 1'b0);

    // Overrun on the 17th byte.
    for (int i = 0; i < 17; i++) deliver_rx(8'(i));
    bus_read(ADDR_STAT);
    check8("stat_overrun", rdata, 8'h0F);
    for (int i = 0; i < 16; i++) begin
      bus_read(ADDR_DATA);
      check8("rx_fill_order", rdata, 8'(i));
    end
    bus_read(ADDR_STAT);
    check1("overrun_cleared", rdata[OVR], 1'b0);

    // TX overflow while the port holds its acknowledge.
    bus_write(ADDR_DATA, 8'hEE);
    idle(2);
    for (int i = 0; i < 17; i++) bus_write(ADDR_DATA, 8'(i));
    bus_read(ADDR_STAT);
    check1("tx_not_full_low", rdata[TX_NF], 1'b0);
    ack_dly = 10; ack_en = 1'b1;
    wait_tx_drain(2000);
    ack_en = 1'b0;
    check8("tx_last_sent", sp_din, 8'h0F);

    // RX interrupt.
    bus_write(ADDR_STAT, 8'h01);
    deliver_rx(8'h5A);
    idle(1);
    check1("irq_rise", irq, 1'b1);
    bus_read(ADDR_DATA);
    check8("irq_rx_byte", rdata, 8'h5A);
    idle(1);
    check1("irq_fall", irq, 1'b0);
    bus_write(ADDR_STAT, 8'h00);

    // Randomised mix of all bus and line operations.
    ack_rand = 1'b1; ack_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: bus_write(ADDR_DATA, 8'($urandom));
        3, 4:    bus_read(ADDR_DATA);
        5:       bus_read(ADDR_STAT);
        6:       bus_write(ADDR_STAT, 8'($urandom_range(0, 3)));
        7, 8:    deliver_rx(8'($urandom));
        default: read_and_rx(8'($urandom));
      endcase
    end
    wait_tx_drain(5000);
    bus_write(ADDR_STAT, 8'h00);
    for (int i = 0; i < 18; i++) bus_read(ADDR_DATA);
    ack_en = 1'b0;
    idle(3);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_residue: got %0d entries expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
